delay_arbiter: RTL and testbench

DELAY_ARBITER -- requirements
Module: delay_arbiter

---
 rtl/delay_arbiter_pkg.sv | 16 +
 rtl/delay_arbiter_rr_pick.sv | 32 +++
 rtl/delay_arbiter.sv | 91 +++++++++
 tb/tb_delay_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_arbiter_pkg.sv
// Shared types and default sizing for the delay_arbiter slice.
// The FSM state type lives here so the top and any future siblings agree on encoding.
package delay_arbiter_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DELAY    = 91;
  localparam int DEF_WD_SLACK = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/delay_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set req bit at or after ptr
// (ascending, wrapping) wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx
);

  logic          found;
  logic [IW-1:0] cand;

  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter handing one shared load-and-wait delay counter to N_REQ
// requesters, with a watchdog that flags an early or missing counter done.
module delay_arbiter
  import delay_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int DELAY    = DEF_DELAY,
  parameter int WD_SLACK = DEF_WD_SLACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             ctr_ld,
  input  logic             ctr_dn,
  output logic             busy,
  output logic             err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(DELAY + WD_SLACK + 1);
  localparam logic [WW-1:0] DLY_CNT = WW'(DELAY);
  localparam logic [WW-1:0] LIM_CNT = WW'(DELAY + WD_SLACK);

  state_t            state;
  logic [WW-1:0]     wait_cnt;
  logic [IW-1:0]     ptr;
  logic [N_REQ-1:0]  pick_oh;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     ptr_next;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // ptr holds the index with top priority, i.e. one past the last winner.
  assign ptr_next = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign busy     = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= '0;
      done     <= '0;
      ctr_ld   <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
      ptr      <= '0;
    end else begin
      done   <= '0;
      ctr_ld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            state  <= S_LOAD;
            gnt    <= pick_oh;
            ctr_ld <= 1'b1;
            ptr    <= ptr_next;
          end
        end
        S_LOAD: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt != LIM_CNT) wait_cnt <= wait_cnt + 1'b1;
          // A dn at or after the nominal cycle completes; early dn or silence is a fault.
          if (ctr_dn && (wait_cnt >= DLY_CNT)) begin
            state <= S_DONE;
            done  <= gnt;
          end else if (ctr_dn || (wait_cnt == LIM_CNT)) begin
            err   <= 1'b1;
            gnt   <= '0;
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          gnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboard bench for delay_arbiter: expected ld/done events are queued when
// requests are driven and matched by a negedge monitor; a counter model drives ctr_dn.
module tb_delay_arbiter;

  localparam int N_REQ    = 4;
  localparam int DELAY    = 91;
  localparam int WD_SLACK = 8;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       ctr_ld;
  logic       ctr_dn;
  logic       busy;
  logic       err;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  dn_delay;
  int  m_cnt = 0;
  logic prev_ld = 1'b0;
  ev_t gq[$];
  ev_t dq[$];
  ev_t mon_e;

  delay_arbiter #(.N_REQ(N_REQ), .DELAY(DELAY), .WD_SLACK(WD_SLACK)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .gnt    (gnt),
    .done   (done),
    .ctr_ld (ctr_ld),
    .ctr_dn (ctr_dn),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: got cycle %0d required finish earlier", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Counter model: dn rises dn_delay cycles after the ld cycle and holds until the next ld.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt  = 0;
      ctr_dn = 1'b0;
    end else if (ctr_ld) begin
      ctr_dn = 1'b0;
      m_cnt  = (dn_delay < 0) ? 0 : dn_delay;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) ctr_dn = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (ctr_ld) begin
      check("ld_one_cycle", 32'(prev_ld), 32'd0);
      if (gq.size() == 0) check("ld_unexpected", 32'(ctr_ld), 32'd0);
      else begin
        mon_e = gq.pop_front();
        check("ld_cycle", cyc, mon_e.cyc);
        check("ld_gnt", 32'(gnt), 32'(mon_e.val));
      end
    end
    if (|done) begin
      if (dq.size() == 0) check("done_unexpected", 32'(done), 32'd0);
      else begin
        mon_e = dq.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("done_val", 32'(done), 32'(mon_e.val));
        check("done_owner", 32'(gnt), 32'(done));
      end
    end
    prev_ld = ctr_ld;
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},  32'(gnt),    32'd0);
    check({tag, "_done"}, 32'(done),   32'd0);
    check({tag, "_ld"},   32'(ctr_ld), 32'd0);
    check({tag, "_busy"}, 32'(busy),   32'd0);
    check({tag, "_err"},  32'(err),    32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
  endtask

  task automatic serve_one(input logic [3:0] req_val, input logic [3:0] exp_oh, input logic exp_err);
    int c;
    @(negedge clk);
    req = req_val;
    c   = cyc;
    gq.push_back('{c + 1, exp_oh});
    dq.push_back('{c + DELAY + 3, exp_oh});
    wait_cyc(c + DELAY + 3);
    req = '0;
    wait_cyc(c + DELAY + 4);
    check("release_gnt",  32'(gnt),  32'd0);
    check("release_busy", 32'(busy), 32'd0);
    check("release_err",  32'(err),  32'(exp_err));
  endtask

  initial begin
    int c;
    rst_n    = 1'b0;
    req      = '0;
    dn_delay = DELAY + 1;
    repeat (3) @(negedge clk);
    check_idle_outputs("por");
    rst_n = 1'b1;

    // Four continuous requesters from reset priority: 0,1,2,3,0 at 95-cycle spacing.
    @(negedge clk);
    req = 4'b1111;
    c   = cyc;
    for (int k = 0; k < 5; k++) begin
      gq.push_back('{c + 1 + 95 * k, 4'(1 << (k % 4))});
      dq.push_back('{c + 94 + 95 * k, 4'(1 << (k % 4))});
    end
    wait_cyc(c + 474);
    req = '0;
    wait_cyc(c + 475);
    check("rr_end_gnt", 32'(gnt), 32'd0);
    check("rr_end_err", 32'(err), 32'd0);

    serve_one(4'b0001, 4'b0001, 1'b0);

    // Early dn 50 cycles after ld.
    dn_delay = 50;
    @(negedge clk);
    req = 4'b0100;
    c   = cyc;
    gq.push_back('{c + 1, 4'b0100});
    wait_cyc(c + 51);
    check("early_pre_err", 32'(err), 32'd0);
    check("early_pre_gnt", 32'(gnt), 32'b0100);
    wait_cyc(c + 52);
    check("early_err",  32'(err),  32'd1);
    check("early_gnt",  32'(gnt),  32'd0);
    check("early_busy", 32'(busy), 32'd0);
    req      = '0;
    dn_delay = DELAY + 1;
    serve_one(4'b1000, 4'b1000, 1'b1);

    // Counter never answers: watchdog fires at wait_cnt == DELAY+WD_SLACK.
    do_reset();
    dn_delay = -1;
    @(negedge clk);
    req = 4'b0010;
    c   = cyc;
    gq.push_back('{c + 1, 4'b0010});
    wait_cyc(c + 101);
    check("to_pre_err",  32'(err),  32'd0);
    check("to_pre_busy", 32'(busy), 32'd1);
    check("to_pre_gnt",  32'(gnt),  32'b0010);
    wait_cyc(c + 102);
    check("to_err",  32'(err),  32'd1);
    check("to_gnt",  32'(gnt),  32'd0);
    check("to_busy", 32'(busy), 32'd0);
    req      = '0;
    dn_delay = DELAY + 1;

    // Reset mid-wait at wait_cnt == 40, then reset priority applies again.
    @(negedge clk);
    req = 4'b0100;
    c   = cyc;
    gq.push_back('{c + 1, 4'b0100});
    wait_cyc(c + 41);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    serve_one(4'b1010, 4'b0010, 1'b0);

    // Owner drops req while waiting; its done still pulses, then the other is served.
    @(negedge clk);
    req = 4'b0101;
    c   = cyc;
    gq.push_back('{c + 1, 4'b0100});
    dq.push_back('{c + 94, 4'b0100});
    wait_cyc(c + 10);
    req = 4'b0001;
    gq.push_back('{c + 96, 4'b0001});
    dq.push_back('{c + 189, 4'b0001});
    wait_cyc(c + 189);
    req = '0;
    wait_cyc(c + 190);
    check("drop_end_gnt",  32'(gnt),  32'd0);
    check("drop_end_busy", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    check("gq_drained", 32'(gq.size()), 32'd0);
    check("dq_drained", 32'(dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
